sysid_check_master: RTL



---
 rtl/sysid_pkg.sv | 23 ++
 rtl/sysid_check_master_timer.sv | 48 ++++
 rtl/sysid_check_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID check master.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    COMPARE
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'd40899754;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1242736836;

  function automatic logic is_read_state(state_e s);
    return (s == RD_ID) || (s == WAIT_ID) || (s == RD_TS) || (s == WAIT_TS);
  endfunction

endpackage

// File: rtl/sysid_check_master_timer.sv
// Per-read timeout down-counter with terminal-count expire, plus whole-sequence retry counter.
module avm_read_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  input  logic retry_clr_i,
  input  logic retry_inc_i,
  output logic expire_o,
  output logic retry_avail_o
);

  // Loading TIMEOUT_CYCLES-1 makes the terminal count land on the last allowed cycle.
  localparam logic [7:0] TC_LOAD = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [2:0] retry_q, retry_d;

  always_comb begin
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (clear_i)
      cnt_d = TC_LOAD;
    else if (run_i && (cnt_q != 8'd0))
      cnt_d = cnt_q - 8'd1;
    if (retry_clr_i)
      retry_d = 3'd0;
    else if (retry_inc_i)
      retry_d = retry_q + 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 8'd0;
      retry_q <= 3'd0;
    end else begin
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  assign expire_o      = run_i && (cnt_q == 8'd0);
  assign retry_avail_o = retry_q < 3'(MAX_RETRIES);

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master: fetches system ID and build timestamp, compares against expected
// constants and reports match/timeout. FSM lives here; timing/retry counting in avm_read_timer.
module sysid_check_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_e      state_q, state_d;
  logic        gap_q, gap_d;
  logic        auto_q, auto_d;
  logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, tmo_q, tmo_d;
  logic [31:0] id_val_q, id_val_d, ts_val_q, ts_val_d;
  logic        t_clear, t_run, t_expire, r_clr, r_inc, r_avail, data_taken;

  avm_read_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (t_clear),
    .run_i        (t_run),
    .retry_clr_i  (r_clr),
    .retry_inc_i  (r_inc),
    .expire_o     (t_expire),
    .retry_avail_o(r_avail)
  );

  // gap_q marks the one idle cycle in RD_ID that separates retry attempts.
  assign t_run = is_read_state(state_q) && !gap_q;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    auto_d      = auto_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    tmo_d       = tmo_q;
    id_val_d    = id_val_q;
    ts_val_d    = ts_val_q;
    avm_address = SYSID_ADDR_ID;
    avm_read    = 1'b0;
    done        = 1'b0;
    t_clear     = 1'b0;
    r_clr       = 1'b0;
    r_inc       = 1'b0;
    data_taken  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          auto_d  = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          tmo_d   = 1'b0;
          r_clr   = 1'b1;
          t_clear = 1'b1;
          state_d = RD_ID;
        end
      end
      RD_ID: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          avm_read = 1'b1;
          if (!avm_waitrequest) begin
            if (avm_readdatavalid) begin
              id_val_d   = avm_readdata;
              data_taken = 1'b1;
              t_clear    = 1'b1;
              state_d    = RD_TS;
            end else begin
              state_d = WAIT_ID;
            end
          end
        end
      end
      WAIT_ID: begin
        if (avm_readdatavalid) begin
          id_val_d   = avm_readdata;
          data_taken = 1'b1;
          t_clear    = 1'b1;
          state_d    = RD_TS;
        end
      end
      RD_TS: begin
        avm_address = SYSID_ADDR_TS;
        avm_read    = 1'b1;
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            ts_val_d   = avm_readdata;
            data_taken = 1'b1;
            state_d    = COMPARE;
          end else begin
            state_d = WAIT_TS;
          end
        end
      end
      WAIT_TS: begin
        avm_address = SYSID_ADDR_TS;
        if (avm_readdatavalid) begin
          ts_val_d   = avm_readdata;
          data_taken = 1'b1;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        id_ok_d = (id_val_q == EXPECTED_ID);
        ts_ok_d = (ts_val_q == EXPECTED_TS);
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Data arriving on the expiring cycle is kept and the timeout is dropped.
    if (t_expire && !data_taken) begin
      if (r_avail) begin
        r_inc   = 1'b1;
        t_clear = 1'b1;
        gap_d   = 1'b1;
        state_d = RD_ID;
      end else begin
        tmo_d   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gap_q    <= 1'b0;
      auto_q   <= AUTO_START;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      tmo_q    <= 1'b0;
      id_val_q <= 32'd0;
      ts_val_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      auto_q   <= auto_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      tmo_q    <= tmo_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = tmo_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;

endmodule
